ram_arbiter: RTL
================

# ram_arbiter

Three-way scheduler for the single-port 64 KB system RAM of the 48K machine. It shares the RAM between three requesters. The video fetch has absolute priority on every pixel clock enable. The CPU and the loader (ioctl download/upload) share the remaining cycles round-robin. It sits between the `cpu`/`video` clients and the synchronous RAM macro, replacing direct per-client ports, and enforces ROM write protection for CPU writes.

## Interface

- `VBASE`, 16'h4000, base address added to the 13-bit video address
- `ROMTOP`, 16'h4000, CPU writes below this address are suppressed
- `ROMPROT`, 1, 1 enables ROM write suppression, 0 disables it
- `clock`  in  1  system clock (56 MHz); every register in the block is clocked on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `vce`  in  1  video slot strobe (pixel ce, one clock in eight)
- `va`  in  13  video fetch address, sampled on `vce`
- `vq`  out  8  video read data, held until next video fetch completes
- `creq`  in  1  CPU access request, level; one access per rising edge of `creq`
- `cwr`  in  1  1 = write, 0 = read; sampled with the request
- `ca`  in  16  CPU address
- `cd`  in  8  CPU write data
- `cq`  out  8  CPU read data, held
- `cack`  out  1  one-clock pulse when the CPU access completes
- `lreq`, `lwr`, `la[15:0]`, `ld[7:0]`  in  loader request, direction, address, write data (same semantics as CPU)
- `lq`  out  8  loader read data, held
- `lack`  out  1  one-clock loader completion pulse
- `mem_a`  out  16  RAM address (registered)
- `mem_d`  out  8  RAM write data (registered)
- `mem_we`  out  1  RAM write enable (registered)
- `mem_q`  in  8  RAM read data, valid one clock after `mem_a`

## Operation

- Request capture: `creq`/`lreq` are delayed one clock. A requester is eligible when (req & !req_d) | pending. Address, data and direction are latched into a per-requester holding register on the rising edge, and `pending` is set if the requester is not granted that cycle. `pending` clears on grant. A request held high yields exactly one access.
- Arbitration runs every clock:
  1. `vce`=1: video is granted. `mem_a` = VBASE + {3'b000, va}, 16-bit add wrapping mod 2^16. `mem_we` = 0.
  2. Otherwise, if exactly one of CPU/loader is eligible, that one is granted.
  3. If both are eligible, the one not granted last time wins. The pointer resets to favour the CPU.
  4. Otherwise idle: `mem_we` = 0, `mem_a` holds.
- Write grant: `mem_d` = write data and `mem_we` = 1. Exception: the CPU with ROMPROT=1 and address < ROMTOP gets `mem_we` = 0. It is still acknowledged and `cq` is unchanged. Loader writes are never suppressed.
- Completion pipeline: a 2-bit owner tag (none/video/CPU/loader) plus a read flag travels through two stages. Stage 2 captures `mem_q` into `vq`/`cq`/`lq` for reads and pulses `cack`/`lack` for CPU/loader (reads and writes).
- A new eligible request can be granted on the clock after its own completion.

## Timing

- E0 is the edge sampling `vce`=1, or the first high sample of an uncontested request.
- `mem_a`/`mem_we`/`mem_d` are valid after E0. `mem_q` is valid after E1. `vq`/`cq`/`lq` and `cack`/`lack` are updated at E2, and the ack is high for exactly the cycle after E2.
- Uncontested CPU/loader latency is 2 clocks. Losing to video adds 1 clock. Losing round-robin adds 1 clock per access ahead.
- Back-to-back grants on consecutive clocks are allowed; the pipeline holds up to 2 accesses in flight.
- Simultaneous `vce` and both requests: video at E0, the round-robin winner at E1, the other at E2.
- A rising `creq` on the same edge as a CPU ack is a new request.
- Reset, taking effect mid-operation: pending flags, tags and ack pulses are cleared, `mem_we`=0, `mem_a`=0, `mem_d`=0, `vq`=0, `cq`=8'hFF, `lq`=8'hFF, pointer favours the CPU. In-flight accesses are dropped with no ack.

## Test plan

- Video read: RAM[16'h5800]=8'h38, `vce`=1 with `va`=13'h1800 → `mem_a`=16'h5800 after E0, `vq`=8'h38 after E2, no ack pulses.
- CPU read/write: CPU writes 8'hA5 to 16'h8000, then reads it back → one `cack` per access 2 clocks after each request, `cq`=8'hA5, `mem_we` high exactly 1 clock.
- ROM protection: CPU writes 8'h00 to 16'h0010 with ROMPROT=1 → `mem_we` stays 0 and `cack` pulses. Loader writes 8'h11 to 16'h0010 → `mem_we`=1 and a readback gives 8'h11.
- Contention: `vce`, CPU read and loader read all rise on the same edge → grants in the order video, CPU, loader on consecutive clocks. Repeating with the pointer favouring the loader → video, loader, CPU.
- Held request: `creq` held high for 20 clocks → exactly one grant and one `cack`. Drop `creq` 1 clock and raise it again → a second access.
- Reset mid-access: assert `reset` the clock after a CPU grant → no `cack`, all outputs at reset values, and the first request after reset completes normally.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: schedules video, CPU and loader accesses onto one single-port RAM
module ram_arbiter #(
  parameter logic [15:0] VBASE = 16'h4000,
  parameter logic [15:0] ROMTOP = 16'h4000,
  parameter bit ROMPROT = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        vce,
  input  logic [12:0] va,
  output logic [7:0]  vq,
  input  logic        creq,
  input  logic        cwr,
  input  logic [15:0] ca,
  input  logic [7:0]  cd,
  output logic [7:0]  cq,
  output logic        cack,
  input  logic        lreq,
  input  logic        lwr,
  input  logic [15:0] la,
  input  logic [7:0]  ld,
  output logic [7:0]  lq,
  output logic        lack,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q
);
  typedef enum logic [1:0] {T_NONE, T_VID, T_CPU, T_LDR} tag_t;
  logic creq_d, lreq_d, cpend, lpend, ptr;
  logic [15:0] ch_a, lh_a;
  logic [7:0] ch_d, lh_d;
  logic ch_wr, lh_wr;
  logic c_rise, l_rise, c_elig, l_elig, c_g, l_g, c_wr, l_wr, c_prot;
  logic [15:0] c_a, l_a;
  logic [7:0] c_d, l_d;
  tag_t s1_tag, s2_tag;
  logic s1_rd, s2_rd;
  // a fresh edge uses the live request fields, a pending one uses the held copy
  always_comb begin
    c_rise = creq & ~creq_d;
    l_rise = lreq & ~lreq_d;
    c_elig = c_rise | cpend;
    l_elig = l_rise | lpend;
    c_a = c_rise ? ca : ch_a;
    c_d = c_rise ? cd : ch_d;
    c_wr = c_rise ? cwr : ch_wr;
    l_a = l_rise ? la : lh_a;
    l_d = l_rise ? ld : lh_d;
    l_wr = l_rise ? lwr : lh_wr;
    c_g = ~vce & c_elig & (~l_elig | ~ptr);
    l_g = ~vce & l_elig & (~c_elig | ptr);
    c_prot = ROMPROT && (c_a < ROMTOP);
  end
  // capture, grant, drive the RAM and retire completions two clocks later
  always_ff @(posedge clock) begin
    if (reset) begin
      creq_d <= 1'b0;
      lreq_d <= 1'b0;
      cpend <= 1'b0;
      lpend <= 1'b0;
      ptr <= 1'b0;
      ch_a <= '0;
      ch_d <= '0;
      ch_wr <= 1'b0;
      lh_a <= '0;
      lh_d <= '0;
      lh_wr <= 1'b0;
      mem_a <= '0;
      mem_d <= '0;
      mem_we <= 1'b0;
      s1_tag <= T_NONE;
      s2_tag <= T_NONE;
      s1_rd <= 1'b0;
      s2_rd <= 1'b0;
      cack <= 1'b0;
      lack <= 1'b0;
      vq <= 8'h00;
      cq <= 8'hFF;
      lq <= 8'hFF;
    end else begin
      creq_d <= creq;
      lreq_d <= lreq;
      if (c_rise) {ch_a, ch_d, ch_wr} <= {ca, cd, cwr};
      if (l_rise) {lh_a, lh_d, lh_wr} <= {la, ld, lwr};
      cpend <= c_elig & ~c_g;
      lpend <= l_elig & ~l_g;
      ptr <= (c_g | l_g) ? c_g : ptr;
      mem_we <= c_g ? (c_wr & ~c_prot) : l_g ? l_wr : 1'b0;
      mem_a <= vce ? VBASE + {3'b000, va} : c_g ? c_a : l_g ? l_a : mem_a;
      mem_d <= c_g ? c_d : l_g ? l_d : mem_d;
      s1_tag <= vce ? T_VID : c_g ? T_CPU : l_g ? T_LDR : T_NONE;
      s1_rd <= vce | (c_g & ~c_wr) | (l_g & ~l_wr);
      s2_tag <= s1_tag;
      s2_rd <= s1_rd;
      cack <= s2_tag == T_CPU;
      lack <= s2_tag == T_LDR;
      vq <= (s2_rd && s2_tag == T_VID) ? mem_q : vq;
      cq <= (s2_rd && s2_tag == T_CPU) ? mem_q : cq;
      lq <= (s2_rd && s2_tag == T_LDR) ? mem_q : lq;
    end
  end
endmodule
